// File: rtl/usb_token_rx.sv
// usb_token_rx: USB token packet decoder (SYNC hunt, PID check, ADDR/ENDP capture, CRC5 check)
// Ports: clk, rst (sync, active-high); bit_in/bit_valid/eop unstuffed serial input, LSB first;
//    tok_valid/tok_pid/tok_addr/tok_endp decoded token; pid_err/crc_err/len_err error pulses; busy.
// Option: define USB_TOKRX_ADDR_FILTER_EN to drop non-SOF tokens not addressed to DEV_ADDR.
module usb_token_rx #(
   parameter int         TIMEOUT_CYC = 64,
   parameter logic [6:0] DEV_ADDR    = 7'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_in,
   input  logic       bit_valid,
   input  logic       eop,
   output logic       tok_valid,
   output logic [3:0] tok_pid,
   output logic [6:0] tok_addr,
   output logic [3:0] tok_endp,
   output logic       pid_err,
   output logic       crc_err,
   output logic       len_err,
   output logic       busy
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [2:0] {HUNT, PID, TOKEN, WAIT_EOP, SKIP} state_t;
   state_t        state_q, state_d;
   logic [2:0]    zcnt_q, zcnt_d;
   logic [3:0]    bcnt_q, bcnt_d;
   logic [7:0]    pid_q, pid_d;
   logic [10:0]   sh_q, sh_d;
   logic [4:0]    crc_q, crc_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tok_valid_d, pid_err_d, crc_err_d, len_err_d;
   logic [3:0]    tok_pid_d, tok_endp_d;
   logic [6:0]    tok_addr_d;
   logic [7:0]    pid_nx;
   logic          fb, pass, tmo_hit, crc_ok;
   assign pid_nx  = {bit_in, pid_q[7:1]};
   assign fb      = bit_in ^ crc_q[4];
   assign tmo_hit = tmo_q == TW'(TIMEOUT_CYC - 1);
   assign crc_ok  = crc_q == 5'b01100;
   assign busy    = state_q != HUNT;
`ifdef USB_TOKRX_ADDR_FILTER_EN
   assign pass = pid_q[3:0] == 4'b0101 || sh_q[6:0] == DEV_ADDR;
`else
   assign pass = 1'b1;
`endif
   always_comb begin
      state_d     = state_q;
      zcnt_d      = zcnt_q;
      bcnt_d      = bcnt_q;
      pid_d       = pid_q;
      sh_d        = sh_q;
      crc_d       = crc_q;
      tmo_d       = '0;
      tok_valid_d = 1'b0;
      pid_err_d   = 1'b0;
      crc_err_d   = 1'b0;
      len_err_d   = 1'b0;
      tok_pid_d   = tok_pid;
      tok_addr_d  = tok_addr;
      tok_endp_d  = tok_endp;
      if (state_q == HUNT) begin
         if (bit_valid && !eop) begin
            zcnt_d = bit_in ? 3'd0 : zcnt_q + 3'(zcnt_q != 3'd7);
            if (bit_in && zcnt_q == 3'd7) begin
               state_d = PID;
               bcnt_d  = '0;
               crc_d   = 5'h1F;
            end
         end
      end else if (eop) begin
         state_d     = HUNT;
         len_err_d   = state_q == PID || state_q == TOKEN;
         tok_valid_d = state_q == WAIT_EOP && crc_ok && pass;
         crc_err_d   = state_q == WAIT_EOP && !crc_ok;
         if (tok_valid_d) {tok_pid_d, tok_addr_d, tok_endp_d} = {pid_q[3:0], sh_q[6:0], sh_q[10:7]};
      end else if (bit_valid) begin
         bcnt_d = bcnt_q + 4'd1;
         case (state_q)
            PID: begin
               pid_d = pid_nx;
               if (bcnt_q == 4'd7) begin
                  pid_err_d = pid_nx[7:4] != ~pid_nx[3:0];
                  // every token PID has 01 in its two low bits
                  state_d   = !pid_err_d && pid_nx[1:0] == 2'b01 ? TOKEN : SKIP;
                  bcnt_d    = '0;
               end
            end
            TOKEN: begin
               // only addr/endp are kept; the CRC field just feeds the checker
               sh_d  = bcnt_q < 4'd11 ? {bit_in, sh_q[10:1]} : sh_q;
               crc_d = {crc_q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
               if (bcnt_q == 4'd15) state_d = WAIT_EOP;
            end
            WAIT_EOP: begin
               len_err_d = 1'b1;
               state_d   = SKIP;
            end
            default: ;
         endcase
      end else begin
         tmo_d = tmo_q + 1'b1;
         if (tmo_hit) begin
            state_d   = HUNT;
            len_err_d = state_q != SKIP;
            tmo_d     = '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HUNT;
         zcnt_q    <= '0;
         bcnt_q    <= '0;
         pid_q     <= '0;
         sh_q      <= '0;
         crc_q     <= 5'h1F;
         tmo_q     <= '0;
         tok_valid <= 1'b0;
         pid_err   <= 1'b0;
         crc_err   <= 1'b0;
         len_err   <= 1'b0;
         tok_pid   <= '0;
         tok_addr  <= '0;
         tok_endp  <= '0;
      end else begin
         state_q   <= state_d;
         zcnt_q    <= zcnt_d;
         bcnt_q    <= bcnt_d;
         pid_q     <= pid_d;
         sh_q      <= sh_d;
         crc_q     <= crc_d;
         tmo_q     <= tmo_d;
         tok_valid <= tok_valid_d;
         pid_err   <= pid_err_d;
         crc_err   <= crc_err_d;
         len_err   <= len_err_d;
         tok_pid   <= tok_pid_d;
         tok_addr  <= tok_addr_d;
         tok_endp  <= tok_endp_d;
      end
   end
endmodule

// File: tb/tb_usb_token_rx.sv
// tb_usb_token_rx: randomized + directed bench for usb_token_rx against a packet-level model
module tb_usb_token_rx;
   localparam logic [6:0] DEV = 7'h15;
   logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, eop = 1'b0;
   logic tok_valid, pid_err, crc_err, len_err, busy;
   logic [3:0] tok_pid, tok_endp;
   logic [6:0] tok_addr;
   int checks = 0, failures = 0;
   int cnt_tv = 0, cnt_pe = 0, cnt_ce = 0, cnt_le = 0;
   logic [3:0] hold_pid = '0, hold_endp = '0;
   logic [6:0] hold_addr = '0;
   usb_token_rx #(.TIMEOUT_CYC(64), .DEV_ADDR(DEV)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .eop(eop),
      .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_addr(tok_addr), .tok_endp(tok_endp),
      .pid_err(pid_err), .crc_err(crc_err), .len_err(len_err), .busy(busy)
   );
   initial forever #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (tok_valid) cnt_tv++;
      if (pid_err) cnt_pe++;
      if (crc_err) cnt_ce++;
      if (len_err) cnt_le++;
      if (tok_valid | pid_err | crc_err | len_err)
         check("onehot", $countones({tok_valid, pid_err, crc_err, len_err}), 1);
   end
   // USB CRC5 generator: returns the 5-bit field as it appears LSB first on the wire
   function automatic logic [4:0] crc5(input logic [10:0] d);
      logic [4:0] r, f;
      r = 5'h1F;
      for (int i = 0; i < 11; i++) r = (r << 1) ^ ((d[i] ^ r[4]) ? 5'h05 : 5'h00);
      for (int j = 0; j < 5; j++) f[j] = ~r[4-j];
      return f;
   endfunction
   function automatic void predict(input logic [7:0] pid, input logic [63:0] pl, input int n,
                                   output int tv, output int pe, output int ce, output int le);
      tv = 0; pe = 0; ce = 0; le = 0;
      if (pid[7:4] != ~pid[3:0]) pe = 1;
      else if (pid[3:0] inside {4'h1, 4'h9, 4'h5, 4'hD}) begin
         if (n != 16) le = 1;
         else if (pl[15:11] != crc5(pl[10:0])) ce = 1;
`ifdef USB_TOKRX_ADDR_FILTER_EN
         else tv = int'(pid[3:0] == 4'h5 || pl[6:0] == DEV);
`else
         else tv = 1;
`endif
      end
   endfunction
   task automatic drive(input logic bv, input logic b, input logic e);
      bit_valid = bv; bit_in = b; eop = e;
      @(posedge clk); #1;
   endtask
   task automatic send_bit(input logic b, input int maxgap);
      int g;
      g = ($urandom_range(3, 0) == 0) ? $urandom_range(maxgap, 0) : 0;
      repeat (g) drive(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      drive(1'b1, b, 1'b0);
   endtask
   task automatic send_hdr(input logic [7:0] pid, input int maxgap);
      repeat (7) send_bit(1'b0, maxgap);
      send_bit(1'b1, maxgap);
      check("busy_sync", busy, 1);
      for (int i = 0; i < 8; i++) send_bit(pid[i], maxgap);
   endtask
   task automatic send_pkt(input logic [7:0] pid, input logic [63:0] pl, input int n, input int maxgap);
      int tv, pe, ce, le, b_tv, b_pe, b_ce, b_le;
      predict(pid, pl, n, tv, pe, ce, le);
      b_tv = cnt_tv; b_pe = cnt_pe; b_ce = cnt_ce; b_le = cnt_le;
      send_hdr(pid, maxgap);
      for (int i = 0; i < n; i++) send_bit(pl[i], maxgap);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1);
      check($sformatf("tv_lat pid=%02h", pid), tok_valid, tv);
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      if (tv != 0) {hold_pid, hold_addr, hold_endp} = {pid[3:0], pl[6:0], pl[10:7]};
      check($sformatf("tv pid=%02h", pid), cnt_tv - b_tv, tv);
      check($sformatf("pe pid=%02h", pid), cnt_pe - b_pe, pe);
      check($sformatf("ce pid=%02h", pid), cnt_ce - b_ce, ce);
      check($sformatf("le pid=%02h", pid), cnt_le - b_le, le);
      check("tok_pid", tok_pid, hold_pid);
      check("tok_addr", tok_addr, hold_addr);
      check("tok_endp", tok_endp, hold_endp);
      check("busy_idle", busy, 0);
   endtask
   initial begin
      logic [7:0] tp[4] = '{8'hE1, 8'h69, 8'hA5, 8'h2D};
      logic [7:0] dp[5] = '{8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E};
      logic [63:0] pl;
      logic [7:0] pid;
      int n, b_le;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_pulses", {tok_valid, pid_err, crc_err, len_err}, 0);
      check("rst_fields", {tok_pid, tok_addr, tok_endp}, 0);
      send_pkt(8'h2D, {5'h02, 4'h0, 7'h00}, 16, 0);
      send_pkt(8'hE1, {5'h17, 4'hE, 7'h15}, 16, 6);
      send_pkt(8'h2D, {5'h03, 4'h0, 7'h00}, 16, 0);
      send_pkt(8'h2C, {5'h02, 4'h0, 7'h00}, 16, 0);
      send_pkt(8'h2D, {5'h02, 4'h0, 7'h00}, 10, 0);
      send_pkt(8'h2D, {47'h0, 1'b1, 5'h02, 4'h0, 7'h00}, 17, 0);
      send_pkt(8'hC3, {$urandom, $urandom}, 40, 2);
      send_pkt(8'hA5, {5'h14, 11'h710}, 16, 1);
      b_le = cnt_le;
      send_hdr(8'h2D, 0);
      repeat (5) send_bit(1'b0, 0);
      repeat (62) drive(1'b0, 1'b0, 1'b0);
      check("tmo_early", cnt_le - b_le, 0);
      check("tmo_busy_early", busy, 1);
      repeat (10) drive(1'b0, 1'b0, 1'b0);
      check("tmo_le", cnt_le - b_le, 1);
      check("tmo_busy", busy, 0);
      send_hdr(8'hE1, 0);
      for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out", {tok_valid, pid_err, crc_err, len_err, tok_pid, tok_addr, tok_endp}, 0);
      {hold_pid, hold_addr, hold_endp} = '0;
      send_pkt(8'h2D, {5'h02, 4'h0, 7'h00}, 16, 0);
      for (int k = 0; k < 150; k++) begin
         pl = {$urandom, $urandom};
         n = 16;
         case ($urandom_range(9, 0))
            0, 1, 2, 3, 4, 5: begin
               pid = tp[$urandom_range(3, 0)];
               if ($urandom_range(1, 0) == 0) pl[6:0] = DEV;
               if ($urandom_range(9, 0) < 7) pl[15:11] = crc5(pl[10:0]);
               if ($urandom_range(5, 0) == 0) n = $urandom_range(20, 0);
            end
            6, 7: begin
               pid = dp[$urandom_range(4, 0)];
               n = $urandom_range(40, 0);
            end
            default: pid = 8'($urandom);
         endcase
         send_pkt(pid, pl, n, $urandom_range(6, 0));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
